infifo_read_sequencer: RTL and testbench
========================================

Name: infifo_read_sequencer

Overview:
- Read-side controller for the NB-bank input FIFO (inFIFO_ne) that feeds the LDPC decoder load stage.
- On each frame-complete pulse from the FIFO writer, it issues READROWS sequential reads (RA = 0..READROWS-1) to all banks in parallel.
- Reads are paced by the decoder's ready signal, each returned row is tagged, and one further frame is queued if it arrives mid-read.
- Sits between the inFIFO load_fsm_start/RA/rd_en interface and the decoder load FSM.

Parameters:
- ADDRESSWIDTH, 5, width of RA; matches FIFO bank address width.
- READROWS, 16, rows per frame per bank (256 write cycles / NB=16 banks); 1 <= READROWS <= 2**ADDRESSWIDTH.
- RDLAT, 1, FIFO read latency in clk cycles from rd_en to valid DOUT_nb (registered read).
- FCW, 16, width of the frame counter.

Ports:
- clk  input  1  system clock; FIFO read clock; FIFO inclk is tied to clk in this configuration.
- rst  input  1  synchronous, active-low reset.
- load_start  input  1  one-cycle pulse (FIFO load_fsm_start): a full frame is resident.
- dec_ready  input  1  decoder can accept a row on the cycle after a read is issued.
- rd_en  output  1  FIFO read enable, all banks.
- RA  output  ADDRESSWIDTH  FIFO read address.
- dout_valid  output  1  DOUT_nb holds valid row data this cycle.
- row_idx  output  ADDRESSWIDTH  row number of the data under dout_valid.
- frame_first  output  1  with dout_valid: row 0 of the frame.
- frame_last  output  1  with dout_valid: row READROWS-1 of the frame.
- busy  output  1  state != IDLE, or a frame is pending.
- frame_done  output  1  one-cycle pulse coincident with the frame_last data beat.
- overrun  output  1  sticky: load_start arrived while a frame was already pending.
- frame_count  output  FCW  frames fully delivered; wraps modulo 2**FCW.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-low (rst).
- Reset values: rd_en=0, RA=0, dout_valid=0, row_idx=0, frame_first=0, frame_last=0, busy=0, frame_done=0, overrun=0, frame_count=0, pending=0, state=IDLE.
- Reset mid-frame: abandons the frame immediately; no frame_done; the in-flight RDLAT pipeline is flushed (dout_valid=0 on the next cycle).
- IDLE state:
  - Enter READ if load_start=1 or pending=1; clear pending on entry; rd_ptr=0.
  - A load_start in the same cycle as a pending exit re-sets pending.
- READ state:
  - rd_en = dec_ready (combinational from the registered state/pointer); RA = rd_ptr.
  - When rd_en=1: rd_ptr increments.
  - When rd_en=1 and rd_ptr == READROWS-1: go to DRAIN.
  - dec_ready=0 stalls the read: rd_en=0, RA holds, no skip.
- DRAIN state:
  - Wait RDLAT cycles for the last data beat, then go to IDLE.
  - A pending frame starts the next frame from IDLE with one idle bubble cycle.
- Return path:
  - An RDLAT-deep shift register carries {issued, rd_ptr, first, last}.
  - dout_valid, row_idx, frame_first and frame_last emerge exactly RDLAT cycles after the corresponding rd_en.
- Frame completion:
  - frame_done = dout_valid & frame_last.
  - frame_count increments on frame_done.
- Pending and overrun:
  - load_start while state != IDLE: set pending if pending=0; otherwise set overrun (sticky until rst).
- Edge cases:
  - READROWS=1: first and last are both set on the single beat.
  - rd_ptr never exceeds READROWS-1, and RA never wraps within a frame.

Decomposition:
- Shared package constants: state encodings IDLE=0, READ=1, DRAIN=2; default READROWS=16 and ADDRESSWIDTH=5 shared with inFIFO_ne_asmmod.
- One natural sub-module: rd_tag_pipe, an RDLAT-stage valid/tag delay line.

Test Plan:
- Basic frame: rst low 2 cycles, then load_start pulse with dec_ready=1 → rd_en high 16 consecutive cycles with RA 0..15. dout_valid follows 1 cycle later with row_idx 0..15. frame_first on row 0, frame_last and frame_done on row 15, frame_count=1, busy low afterwards.
- Back-pressure: dec_ready low on cycles 3-5 of the read → RA holds at 3 while stalled; all 16 rows are delivered exactly once and in order; frame_done after 19 read-phase cycles.
- Pending frame: second load_start at row 8 of frame 1 → pending set; frame 2 starts after DRAIN plus one IDLE cycle; frame_count=2; overrun=0.
- Overrun: three load_start pulses within one frame → overrun=1 and stays 1; exactly 2 frames are delivered.
- Reset mid-read: rst low at RA=7 → next cycle all outputs are at reset values, no frame_done, frame_count unchanged at 0.
- Configuration check: READROWS=1, RDLAT=2 → a single beat with frame_first=frame_last=1, arriving 2 cycles after rd_en.

Source files
------------

// File: rtl/infifo_read_sequencer_pkg.sv
// Shared state encodings and default geometry for the inFIFO read sequencer.
package infifo_read_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rs_state_e;

  // Geometry shared with inFIFO_ne_asmmod
  localparam int DEF_ADDRESSWIDTH = 5;
  localparam int DEF_READROWS     = 16;
  localparam int DEF_RDLAT        = 1;
  localparam int DEF_FCW          = 16;

endpackage

// File: rtl/infifo_read_sequencer_tag_pipe.sv
// RDLAT-deep delay line carrying {issued, row, first, last} alongside the FIFO read latency.
module rd_tag_pipe
  import infifo_read_sequencer_pkg::*;
#(
  parameter int ADDRESSWIDTH = DEF_ADDRESSWIDTH,
  parameter int RDLAT        = DEF_RDLAT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [ADDRESSWIDTH-1:0] in_idx,
  input  logic                    in_first,
  input  logic                    in_last,
  output logic                    out_valid,
  output logic [ADDRESSWIDTH-1:0] out_idx,
  output logic                    out_first,
  output logic                    out_last
);

  logic [RDLAT-1:0]        valid_r;
  logic [ADDRESSWIDTH-1:0] idx_r   [RDLAT];
  logic                    first_r [RDLAT];
  logic                    last_r  [RDLAT];

  // Shift valid every cycle; tags only advance with a valid beat so row_idx holds the last row
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_r <= '0;
      for (int i = 0; i < RDLAT; i++) begin
        idx_r[i]   <= '0;
        first_r[i] <= 1'b0;
        last_r[i]  <= 1'b0;
      end
    end else begin
      valid_r[0] <= in_valid;
      if (in_valid) begin
        idx_r[0]   <= in_idx;
        first_r[0] <= in_first;
        last_r[0]  <= in_last;
      end
      for (int i = 1; i < RDLAT; i++) begin
        valid_r[i] <= valid_r[i-1];
        if (valid_r[i-1]) begin
          idx_r[i]   <= idx_r[i-1];
          first_r[i] <= first_r[i-1];
          last_r[i]  <= last_r[i-1];
        end
      end
    end
  end

  assign out_valid = valid_r[RDLAT-1];
  assign out_idx   = idx_r[RDLAT-1];
  assign out_first = valid_r[RDLAT-1] & first_r[RDLAT-1];
  assign out_last  = valid_r[RDLAT-1] & last_r[RDLAT-1];

endmodule

// File: rtl/infifo_read_sequencer.sv
// Read-side controller for inFIFO_ne: walks RA 0..READROWS-1 per frame, paced by dec_ready,
// queues at most one extra frame and tags each returned row for the decoder load FSM.
module infifo_read_sequencer
  import infifo_read_sequencer_pkg::*;
#(
  parameter int ADDRESSWIDTH = DEF_ADDRESSWIDTH,
  parameter int READROWS     = DEF_READROWS,
  parameter int RDLAT        = DEF_RDLAT,
  parameter int FCW          = DEF_FCW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic                    dec_ready,
  output logic                    rd_en,
  output logic [ADDRESSWIDTH-1:0] RA,
  output logic                    dout_valid,
  output logic [ADDRESSWIDTH-1:0] row_idx,
  output logic                    frame_first,
  output logic                    frame_last,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun,
  output logic [FCW-1:0]          frame_count
);

  localparam logic [ADDRESSWIDTH-1:0] LAST_ROW = ADDRESSWIDTH'(READROWS - 1);

  rs_state_e               state_r;
  logic [ADDRESSWIDTH-1:0] rd_ptr_r;
  logic                    pending_r;
  logic                    overrun_r;
  logic [7:0]              drain_cnt_r;
  logic [FCW-1:0]          frame_count_r;

  assign rd_en = (state_r == READ) & dec_ready;
  assign RA    = rd_ptr_r;

  // Frame sequencing, one-deep pending queue, overrun flag and delivered-frame counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= IDLE;
      rd_ptr_r      <= '0;
      pending_r     <= 1'b0;
      overrun_r     <= 1'b0;
      drain_cnt_r   <= 8'd0;
      frame_count_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load_start | pending_r) begin
            state_r   <= READ;
            rd_ptr_r  <= '0;
            pending_r <= pending_r & load_start;
          end
        end
        READ: begin
          // Pointer parks on the last row so RA never wraps inside a frame
          if (rd_en) begin
            if (rd_ptr_r == LAST_ROW) begin
              state_r     <= DRAIN;
              drain_cnt_r <= 8'd0;
            end else begin
              rd_ptr_r <= rd_ptr_r + ADDRESSWIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_r == 8'(RDLAT - 1)) begin
            state_r <= IDLE;
          end else begin
            drain_cnt_r <= drain_cnt_r + 8'd1;
          end
        end
        default: state_r <= IDLE;
      endcase

      if ((state_r != IDLE) && load_start) begin
        if (!pending_r) begin
          pending_r <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end

      if (frame_done) begin
        frame_count_r <= frame_count_r + FCW'(1);
      end
    end
  end

  rd_tag_pipe #(
    .ADDRESSWIDTH(ADDRESSWIDTH),
    .RDLAT       (RDLAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_en),
    .in_idx   (rd_ptr_r),
    .in_first (rd_ptr_r == '0),
    .in_last  (rd_ptr_r == LAST_ROW),
    .out_valid(dout_valid),
    .out_idx  (row_idx),
    .out_first(frame_first),
    .out_last (frame_last)
  );

  assign frame_done  = dout_valid & frame_last;
  assign busy        = (state_r != IDLE) | pending_r;
  assign overrun     = overrun_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_infifo_read_sequencer.sv
// Directed bench: table-driven basic frame plus hand sequences for stall, pending, overrun,
// mid-read reset and a READROWS=1 / RDLAT=2 instance.
module tb_infifo_read_sequencer;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic        dec_ready;
  logic        rd_en;
  logic [4:0]  RA;
  logic        dout_valid;
  logic [4:0]  row_idx;
  logic        frame_first;
  logic        frame_last;
  logic        busy;
  logic        frame_done;
  logic        overrun;
  logic [15:0] frame_count;

  logic        load_start2;
  logic        rd_en2;
  logic [4:0]  RA2;
  logic        dout_valid2;
  logic [4:0]  row_idx2;
  logic        frame_first2;
  logic        frame_last2;
  logic        busy2;
  logic        frame_done2;
  logic        overrun2;
  logic [15:0] frame_count2;

  int total;
  int bad;

  infifo_read_sequencer #(.ADDRESSWIDTH(5), .READROWS(16), .RDLAT(1), .FCW(16)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .dec_ready(dec_ready),
    .rd_en(rd_en), .RA(RA), .dout_valid(dout_valid), .row_idx(row_idx),
    .frame_first(frame_first), .frame_last(frame_last), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .frame_count(frame_count)
  );

  infifo_read_sequencer #(.ADDRESSWIDTH(5), .READROWS(1), .RDLAT(2), .FCW(16)) dut2 (
    .clk(clk), .rst(rst), .load_start(load_start2), .dec_ready(dec_ready),
    .rd_en(rd_en2), .RA(RA2), .dout_valid(dout_valid2), .row_idx(row_idx2),
    .frame_first(frame_first2), .frame_last(frame_last2), .busy(busy2),
    .frame_done(frame_done2), .overrun(overrun2), .frame_count(frame_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_v;
    logic        ls_v;
    logic        dr_v;
    logic [32:0] exp;
  } vec_t;

  vec_t vecs [19];

  function automatic logic [32:0] mk(logic re, logic [4:0] ra, logic dv, logic [4:0] ri,
                                     logic ff, logic fl, logic bs, logic fd, logic ov,
                                     logic [15:0] fc);
    return {re, ra, dv, ri, ff, fl, bs, fd, ov, fc};
  endfunction

  function automatic logic [32:0] obs();
    return {rd_en, RA, dout_valid, row_idx, frame_first, frame_last, busy, frame_done,
            overrun, frame_count};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Apply inputs on the falling edge, then let outputs settle before sampling
  task automatic cyc(input logic r, input logic ls, input logic dr, input logic ls2);
    @(negedge clk);
    rst         = r;
    load_start  = ls;
    dec_ready   = dr;
    load_start2 = ls2;
    #1;
  endtask

  initial begin
    int  exp_row;
    int  dones;
    bit  seen;
    bit  any_rd;

    total = 0;
    bad   = 0;
    rst = 1'b0; load_start = 1'b0; dec_ready = 1'b0; load_start2 = 1'b0;

    vecs[0] = '{1'b1, 1'b1, 1'b1, mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0)};
    for (int k = 0; k < 16; k++) begin
      vecs[1+k] = '{1'b1, 1'b0, 1'b1,
                    mk(1'b1, 5'(k), k >= 1, (k >= 1) ? 5'(k-1) : 5'd0, k == 1, 1'b0,
                       1'b1, 1'b0, 1'b0, 16'd0)};
    end
    vecs[17] = '{1'b1, 1'b0, 1'b1, mk(1'b0, 5'd15, 1'b1, 5'd15, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0)};
    vecs[18] = '{1'b1, 1'b0, 1'b1, mk(1'b0, 5'd15, 1'b0, 5'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1)};

    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Basic frame, row by row
    for (int i = 0; i < 19; i++) begin
      cyc(vecs[i].rst_v, vecs[i].ls_v, vecs[i].dr_v, 1'b0);
      chk($sformatf("basic_r%0d", i), 64'(obs()), 64'(vecs[i].exp));
    end

    // Back-pressure: dec_ready low on read cycles 3..5
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    exp_row = 0;
    seen    = 1'b0;
    for (int n = 0; n < 40; n++) begin
      cyc(1'b1, 1'b0, !(n >= 3 && n <= 5), 1'b0);
      if (n >= 3 && n <= 5) chk($sformatf("bp_stall_ra_n%0d", n), 64'({rd_en, RA}), 64'({1'b0, 5'd3}));
      if (dout_valid) begin
        chk("bp_row_order", 64'(row_idx), 64'(exp_row));
        exp_row++;
      end
      if (frame_done && !seen) begin
        chk("bp_done_cycle", 64'(n), 64'd19);
        seen = 1'b1;
      end
      if (seen && !busy) break;
    end
    chk("bp_done_seen", 64'(seen), 64'd1);
    chk("bp_rows", 64'(exp_row), 64'd16);
    chk("bp_count", 64'(frame_count), 64'd2);

    // Pending frame queued at row 8
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    dones = 0;
    for (int n = 0; n < 80; n++) begin
      cyc(1'b1, n == 8, 1'b1, 1'b0);
      if (n == 17) chk("pend_bubble", 64'({rd_en, busy}), 64'({1'b0, 1'b1}));
      if (n == 18) chk("pend_restart", 64'({rd_en, RA}), 64'({1'b1, 5'd0}));
      if (frame_done) dones++;
      if (dones == 2 && !busy) break;
    end
    chk("pend_frames", 64'(dones), 64'd2);
    chk("pend_count", 64'(frame_count), 64'd4);
    chk("pend_no_overrun", 64'(overrun), 64'd0);

    // Overrun: three starts within one frame
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    dones = 0;
    for (int n = 0; n < 80; n++) begin
      cyc(1'b1, n == 2 || n == 5, 1'b1, 1'b0);
      if (n == 7) chk("ovr_set", 64'(overrun), 64'd1);
      if (frame_done) dones++;
      if (dones == 2 && !busy) break;
    end
    chk("ovr_frames", 64'(dones), 64'd2);
    chk("ovr_sticky", 64'(overrun), 64'd1);
    chk("ovr_count", 64'(frame_count), 64'd6);
    any_rd = 1'b0;
    for (int n = 0; n < 10; n++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      if (rd_en || busy) any_rd = 1'b1;
    end
    chk("ovr_no_third", 64'(any_rd), 64'd0);

    // Reset while RA=7
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 8; n++) begin
      cyc(n != 7, 1'b0, 1'b1, 1'b0);
      if (n == 7) chk("rst_at_ra7", 64'({rd_en, RA}), 64'({1'b1, 5'd7}));
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst_outputs", 64'(obs()), 64'd0);
    seen = 1'b0;
    for (int n = 0; n < 5; n++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      if (frame_done || dout_valid || busy) seen = 1'b1;
    end
    chk("rst_quiet", 64'({seen, frame_count}), 64'd0);

    // READROWS=1, RDLAT=2 instance
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("cfg_issue", 64'({rd_en2, RA2, dout_valid2}), 64'({1'b1, 5'd0, 1'b0}));
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("cfg_lat1", 64'({rd_en2, dout_valid2}), 64'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("cfg_beat", 64'({dout_valid2, frame_first2, frame_last2, frame_done2, row_idx2}),
        64'({4'hF, 5'd0}));
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("cfg_after", 64'({dout_valid2, busy2, frame_count2}), 64'({1'b0, 1'b0, 16'd1}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
